icache_set_assoc: RTL

ICACHE_SET_ASSOC -- requirements
Module: icache_set_assoc

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_set_assoc_if.sv | 35 +++
 rtl/icache_plru.sv | 53 +++++
 rtl/icache_set_assoc.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    // Byte-within-word offset width.
    function automatic int boff_w(input int word_size);
        return $clog2(word_size / 8);
    endfunction

    // Word-within-line offset width (line must hold at least two words).
    function automatic int woff_w(input int word_size, input int block_width);
        return $clog2(block_width / word_size);
    endfunction

    // Set index width (at least two sets).
    function automatic int idx_w(input int set_count);
        return $clog2(set_count);
    endfunction

    // Way number width; a direct-mapped cache still carries one bit.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Tree-PLRU node count per set; one dummy bit when direct-mapped.
    function automatic int plru_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/icache_set_assoc_if.sv
// Fetch-side and refill-side signals of the instruction cache.
interface icache_set_assoc_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WIDTH = 512
);
    logic                   i_req_valid;
    logic [ADDR_WIDTH-1:0]  i_instr_addr;
    logic                   i_flush;
    logic [WORD_SIZE-1:0]   o_instr;
    logic                   o_hit;
    logic                   o_stall;
    logic                   o_instr_addr_ma;
    logic                   o_mem_req_valid;
    logic                   i_mem_req_ready;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic                   i_mem_data_valid;
    logic [BLOCK_WIDTH-1:0] i_mem_data;

    // Cache side.
    modport slave (
        input  i_req_valid, i_instr_addr, i_flush,
        input  i_mem_req_ready, i_mem_data_valid, i_mem_data,
        output o_instr, o_hit, o_stall, o_instr_addr_ma,
        output o_mem_req_valid, o_mem_addr
    );

    // Fetch stage plus memory side.
    modport master (
        output i_req_valid, i_instr_addr, i_flush,
        output i_mem_req_ready, i_mem_data_valid, i_mem_data,
        input  o_instr, o_hit, o_stall, o_instr_addr_ma,
        input  o_mem_req_valid, o_mem_addr
    );
endinterface

// File: rtl/icache_plru.sv
// Tree-PLRU for one set: next state after touching a way, and victim choice
// (lowest invalid way first, otherwise the way the tree points at).
module icache_plru
    import icache_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WW = way_w(WAYS),
    localparam int PW = plru_w(WAYS)
) (
    input  logic [PW-1:0]   state,
    input  logic [WAYS-1:0] valid,
    input  logic [WW-1:0]   way,
    output logic [PW-1:0]   next_state,
    output logic [WW-1:0]   victim
);
    generate
        if (WAYS == 1) begin : g_dm
            logic unused_plru;
            assign unused_plru = ^{state, valid, way};
            assign next_state  = '0;
            assign victim      = '0;
        end else begin : g_tree
            localparam int LV = $clog2(WAYS);

            // Walk root to leaf along the touched way; each node points to the other half.
            always_comb begin
                int node;
                next_state = state;
                node = 0;
                for (int l = 0; l < LV; l++) begin
                    next_state[node] = ~way[LV-1-l];
                    node = 2 * node + 1 + int'(way[LV-1-l]);
                end
            end

            // Follow node bits to a leaf; an invalid way overrides the tree.
            always_comb begin
                int node;
                logic [WW-1:0] tree_v;
                tree_v = '0;
                node = 0;
                for (int l = 0; l < LV; l++) begin
                    tree_v[LV-1-l] = state[node];
                    node = 2 * node + 1 + int'(state[node]);
                end
                victim = tree_v;
                for (int w = WAYS - 1; w >= 0; w--) begin
                    if (!valid[w]) victim = WW'(w);
                end
            end
        end
    endgenerate
endmodule

// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache: combinational lookup, single outstanding
// line refill, deferred fence.i flush and hit/miss counters.
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int SET_COUNT   = 128,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WIDTH = 512,
    parameter int ADDR_WIDTH  = 64
) (
    input  logic               clk,
    input  logic               arst,
    icache_set_assoc_if.slave  bus,
    output logic [31:0]        o_hit_count,
    output logic [31:0]        o_miss_count
);
    localparam int BOFF = boff_w(WORD_SIZE);
    localparam int WOFF = woff_w(WORD_SIZE, BLOCK_WIDTH);
    localparam int IDXW = idx_w(SET_COUNT);
    localparam int LOW  = BOFF + WOFF;
    localparam int TAGW = ADDR_WIDTH - LOW - IDXW;
    localparam int WW   = way_w(WAYS);
    localparam int PW   = plru_w(WAYS);

    // Storage: tags and lines are plain RAM, valid and PLRU bits reset.
    logic [TAGW-1:0]        tag_mem  [SET_COUNT][WAYS];
    logic [BLOCK_WIDTH-1:0] data_mem [SET_COUNT][WAYS];
    logic [SET_COUNT-1:0][WAYS-1:0] valid_q;
    logic [SET_COUNT-1:0][PW-1:0]   plru_q;

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-LOW-1:0]  addr_q;     // tag+index of the line being refilled
    logic [BLOCK_WIDTH-1:0]     line_q;
    logic                       flush_pend_q;

    logic [IDXW-1:0] req_idx, fill_idx, plru_idx;
    logic [TAGW-1:0] req_tag, fill_tag;
    logic [WOFF-1:0] req_woff;
    logic [WAYS-1:0] match;
    logic [WW-1:0]   hit_way, victim, plru_way;
    logic [PW-1:0]   plru_nxt;
    logic            one_match, idle, flush_now, lookup, hit, miss;

    assign req_idx  = bus.i_instr_addr[LOW +: IDXW];
    assign req_tag  = bus.i_instr_addr[ADDR_WIDTH-1 -: TAGW];
    assign req_woff = bus.i_instr_addr[BOFF +: WOFF];
    assign fill_idx = addr_q[IDXW-1:0];
    assign fill_tag = addr_q[IDXW +: TAGW];

    assign bus.o_instr_addr_ma = |bus.i_instr_addr[1:0];
    assign idle      = (state_q == S_IDLE);
    // A pending flush is only ever seen in IDLE, right after the refill finishes.
    assign flush_now = bus.i_flush | flush_pend_q;
    assign lookup    = idle & bus.i_req_valid & ~bus.o_instr_addr_ma & ~flush_now;

    // Parallel tag compare across the indexed set; only a unique match is a hit.
    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid_q[req_idx][w] && (tag_mem[req_idx][w] == req_tag);
            if (match[w]) hit_way = WW'(w);
        end
        one_match = (match != '0) && ((match & (match - WAYS'(1))) == '0);
    end

    assign hit  = lookup & one_match;
    assign miss = lookup & ~one_match;

    assign bus.o_hit   = hit;
    assign bus.o_instr = hit ? data_mem[req_idx][hit_way][req_woff*WORD_SIZE +: WORD_SIZE]
                             : '0;
    assign bus.o_mem_req_valid = (state_q == S_REQ);
    assign bus.o_mem_addr      = {addr_q, {LOW{1'b0}}};

    // The PLRU port serves the looked-up set in IDLE and the refilled set in FILL.
    assign plru_idx = (state_q == S_FILL) ? fill_idx : req_idx;
    assign plru_way = (state_q == S_FILL) ? victim : hit_way;

    icache_plru #(.WAYS(WAYS)) u_plru (
        .state      (plru_q[plru_idx]),
        .valid      (valid_q[plru_idx]),
        .way        (plru_way),
        .next_state (plru_nxt),
        .victim     (victim)
    );

    // Refill sequencing; stall is raised in the miss cycle itself.
    always_comb begin
        state_d     = state_q;
        bus.o_stall = 1'b0;
        unique case (state_q)
            S_IDLE: if (miss) begin
                state_d     = S_REQ;
                bus.o_stall = 1'b1;
            end
            S_REQ: begin
                bus.o_stall = 1'b1;
                if (bus.i_mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                bus.o_stall = 1'b1;
                if (bus.i_mem_data_valid) state_d = S_FILL;
            end
            S_FILL: begin
                bus.o_stall = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, valid/PLRU bookkeeping and counters.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            plru_q       <= '0;
            flush_pend_q <= 1'b0;
            addr_q       <= '0;
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (hit)  o_hit_count  <= o_hit_count + 32'd1;
            if (miss) begin
                o_miss_count <= o_miss_count + 32'd1;
                addr_q       <= bus.i_instr_addr[ADDR_WIDTH-1:LOW];
            end
            if (idle && flush_now) begin
                valid_q      <= '0;
                plru_q       <= '0;
                flush_pend_q <= 1'b0;
            end else begin
                if (!idle && bus.i_flush) flush_pend_q <= 1'b1;
                if (hit) plru_q[req_idx] <= plru_nxt;
                if (state_q == S_FILL) begin
                    valid_q[fill_idx][victim] <= 1'b1;
                    plru_q[fill_idx]          <= plru_nxt;
                end
            end
        end
    end

    // Line buffer and array writes; contents need no reset since valid gates them.
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && bus.i_mem_data_valid) line_q <= bus.i_mem_data;
        if (state_q == S_FILL) begin
            tag_mem[fill_idx][victim]  <= fill_tag;
            data_mem[fill_idx][victim] <= line_q;
        end
    end
endmodule
